// File: rtl/flush_ctrl.sv
// -----------------------------------------------------------------------------
// flush_ctrl
//
// Branch-misprediction flush controller. When the branch resolving in EX
// disagrees with its prediction, younger instructions are killed for
// FLUSH_CYCLES non-stalled cycles. Fetch is redirected to the correct path
// with a one-cycle strobe.
//
// Optional feature: define FLUSH_CTRL_STATS_EN to build saturating branch and
// misprediction statistics counters. When the macro is undefined, no counter
// registers exist and both counter outputs read 0.
//
// Parameters
//   WIDTH        PC width in bits
//   FLUSH_CYCLES flush length in non-stalled cycles, 1..15
//   CNT_WIDTH    statistics counter width
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   branch_inst    in   resolving branch present in EX this cycle
//   result         in   resolved direction (1 = taken)
//   prediction     in   predicted direction (1 = taken)
//   save_pc        in   PC of the resolving branch
//   target_pc      in   resolved taken target
//   stall          in   pipeline frozen this cycle
//   flush          out  kill younger instructions
//   redirect_valid out  one-cycle fetch redirect strobe
//   redirect_pc    out  fetch redirect address
//   busy           out  controller is in the FLUSH state
//   mispredict_cnt out  mispredictions accepted
//   branch_cnt     out  branches accepted
//   state_dbg      out  current FSM state (0 = IDLE, 1 = FLUSH)
//
// Handshake: redirect_valid/redirect_pc form a valid-only strobe. Fetch has
// no ready/backpressure input; it must take the redirect in the cycle
// redirect_valid is high. A stall freezes the strobe, so a redirect raised
// just before a stall stays visible until the pipeline moves again.
// -----------------------------------------------------------------------------
module flush_ctrl #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 branch_inst,
  input  logic                 result,
  input  logic                 prediction,
  input  logic [WIDTH-1:0]     save_pc,
  input  logic [WIDTH-1:0]     target_pc,
  input  logic                 stall,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [WIDTH-1:0]     redirect_pc,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] mispredict_cnt,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic                 state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // The detection cycle is the first flush cycle, so FLUSH covers the rest.
  localparam logic [3:0] RELOAD     = 4'(FLUSH_CYCLES - 1);
  // With a single-cycle flush there is nothing left to hold in FLUSH.
  localparam bit         MULTI_CYC  = (FLUSH_CYCLES > 1);

  state_e           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic busy_w;
  logic mispredict;
  logic accept;

  assign busy_w     = (state_q == FLUSH);
  // Branches seen while busy sit in stages being flushed; they are ignored.
  assign mispredict = branch_inst & (result != prediction) & ~busy_w;
  assign accept     = mispredict & ~stall;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. A stall freezes state and remaining count; a
  // mispredict under stall is not taken because the branch re-presents.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (mispredict && MULTI_CYC) begin
            state_d = FLUSH;
            rem_d   = RELOAD;
          end
        end
        FLUSH: begin
          // <= 1 rather than == 1 so a corrupted zero count cannot wedge FLUSH.
          if (rem_q <= 4'd1) begin
            state_d = IDLE;
            rem_d   = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. flush rises combinationally in the detection cycle so the
  // instruction fetched behind the branch never commits; reset masks it.
  // ---------------------------------------------------------------------------
  always_comb begin
    flush     = reset & (busy_w | mispredict);
    busy      = busy_w;
    state_dbg = state_q;
  end

  // ---------------------------------------------------------------------------
  // Redirect datapath: captured on an accepted mispredict, held under stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    if (!stall) begin
      redirect_valid_d = accept;
      if (accept) begin
        // Not-taken path wraps naturally at 2^WIDTH.
        redirect_pc_d = result ? target_pc : (save_pc + WIDTH'(4));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  // ---------------------------------------------------------------------------
  // Statistics counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef FLUSH_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (branch_inst && !busy_w && !stall && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (accept && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flush_ctrl
//
// Runs three flush_ctrl instances side by side (FLUSH_CYCLES = 1, 2, 5, with
// 4-bit statistics counters) on shared stimulus and checks them against a
// behavioural model that tracks "flush cycles still owed" as a plain integer.
// -----------------------------------------------------------------------------
module tb_flush_ctrl;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam int VW = 3 + W + 2 * CW;

  logic          clk;
  logic          reset;
  logic          branch_inst;
  logic          result;
  logic          prediction;
  logic [W-1:0]  save_pc;
  logic [W-1:0]  target_pc;
  logic          stall;

  logic          flush_o [N];
  logic          rv_o    [N];
  logic [W-1:0]  rpc_o   [N];
  logic          busy_o  [N];
  logic [CW-1:0] mis_o   [N];
  logic [CW-1:0] br_o    [N];
  logic          st_o    [N];

  // reference model state
  int            m_left [N];
  logic          m_rv   [N];
  logic [W-1:0]  m_rpc  [N];
  int            m_br   [N];
  int            m_mis  [N];

  int n_checks;
  int n_fail;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int FC = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    flush_ctrl #(
      .WIDTH       (W),
      .FLUSH_CYCLES(FC),
      .CNT_WIDTH   (CW)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .branch_inst   (branch_inst),
      .result        (result),
      .prediction    (prediction),
      .save_pc       (save_pc),
      .target_pc     (target_pc),
      .stall         (stall),
      .flush         (flush_o[g]),
      .redirect_valid(rv_o[g]),
      .redirect_pc   (rpc_o[g]),
      .busy          (busy_o[g]),
      .mispredict_cnt(mis_o[g]),
      .branch_cnt    (br_o[g]),
      .state_dbg     (st_o[g])
    );
  end

  function automatic int fc(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
  endfunction

  // ---------------------------------------------------------------------------
  // reference model
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_left[i] = 0;
      m_rv[i]   = 1'b0;
      m_rpc[i]  = '0;
      m_br[i]   = 0;
      m_mis[i]  = 0;
    end
  endtask

  // Expected {flush, busy, redirect_valid, redirect_pc, branch_cnt, mispredict_cnt}
  function automatic logic [VW-1:0] exp_vec(input int i);
    logic          bz;
    logic          mp;
    logic [CW-1:0] eb;
    logic [CW-1:0] em;
    bz = (m_left[i] > 0);
    mp = branch_inst && (result != prediction) && !bz;
`ifdef FLUSH_CTRL_STATS_EN
    eb = CW'(m_br[i]);
    em = CW'(m_mis[i]);
`else
    eb = '0;
    em = '0;
`endif
    if (!reset) return '0;
    return {bz | mp, bz, m_rv[i], m_rpc[i], eb, em};
  endfunction

  function automatic logic [VW-1:0] obs_vec(input int i);
    return {flush_o[i], busy_o[i], rv_o[i], rpc_o[i], br_o[i], mis_o[i]};
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic bz;
    logic mp;
    for (int i = 0; i < N; i++) begin
      bz = (m_left[i] > 0);
      mp = branch_inst && (result != prediction) && !bz;
      if (!stall) begin
        if (bz)      m_left[i] = m_left[i] - 1;
        else if (mp) m_left[i] = fc(i) - 1;
        m_rv[i] = mp;
        if (mp) m_rpc[i] = result ? target_pc : save_pc + 32'd4;
        if (!bz && branch_inst) m_br[i] = (m_br[i] < 15) ? m_br[i] + 1 : 15;
        if (mp) m_mis[i] = (m_mis[i] < 15) ? m_mis[i] + 1 : 15;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic bi, input logic r, input logic p,
                       input logic [W-1:0] sp, input logic [W-1:0] tp,
                       input logic st);
    branch_inst = bi;
    result      = r;
    prediction  = p;
    save_pc     = sp;
    target_pc   = tp;
    stall       = st;
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      advance();
    end
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    // A mispredicting branch under reset must not raise flush.
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (obs_vec(i) !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h expected 0", i, obs_vec(i));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_taken_mispredict();
    idle(6);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0);
      else        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL taken c%0d dut%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      // FLUSH_CYCLES=2 instance against the fixed timeline
      n_checks++;
      if (c == 0 && flush_o[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL taken_T flush: got %b expected 1", flush_o[1]);
      end else if (c == 1 && {flush_o[1], busy_o[1], rv_o[1], rpc_o[1]} !== {3'b111, 32'h40}) begin
        n_fail++;
        $display("FAIL taken_T1 flush/busy/rv/pc: got %b%b%b %h expected 111 00000040",
                 flush_o[1], busy_o[1], rv_o[1], rpc_o[1]);
      end else if (c == 2 && flush_o[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL taken_T2 flush: got %b expected 0", flush_o[1]);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    idle(6);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234, 1'b0);
    @(negedge clk);
    advance();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (obs_vec(i) !== exp_vec(i) || rv_o[i] !== 1'b1 || rpc_o[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL wrap dut%0d: got %h expected %h (pc 0, rv 1)", i, obs_vec(i), exp_vec(i));
      end
    end
    advance();
  endtask

  task automatic test_stall_in_flush();
    int flen [N];
    idle(6);
    for (int i = 0; i < N; i++) flen[i] = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0)     drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h500, 1'b0);
      else if (c < 4) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      else            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (flush_o[i] === 1'b1) flen[i]++;
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL stall c%0d dut%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      advance();
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (flen[i] != ((i == 0) ? 1 : fc(i) + 3)) begin
        n_fail++;
        $display("FAIL stall_len dut%0d: got %0d expected %0d", i, flen[i],
                 (i == 0) ? 1 : fc(i) + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rvc [N];
    idle(6);
    for (int i = 0; i < N; i++) rvc[i] = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0);
      else if (c == 1) drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h900, 1'b0);
      else             drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rv_o[i] === 1'b1) rvc[i]++;
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL b2b c%0d dut%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      advance();
    end
    // Only the single-cycle instance is idle again when the second arrives.
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (rvc[i] != ((i == 0) ? 2 : 1)) begin
        n_fail++;
        $display("FAIL b2b_redirects dut%0d: got %0d expected %0d", i, rvc[i], (i == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    idle(6);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h640, 1'b0);
    @(negedge clk);
    advance();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (obs_vec(i) !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_flush dut%0d: got %h expected 0", i, obs_vec(i));
      end
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    // first edge after release must act as IDLE: mispredict accepted at once
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 1'b1, 32'h700, 32'h0, 1'b0);
      else        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL post_reset c%0d dut%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic d;
    logic [CW-1:0] exp_br;
    reset = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      d = 1'($urandom_range(0, 1));
      drive(1'b1, d, d, $urandom, $urandom, 1'b0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (flush_o[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_flush c%0d dut%0d: got %b expected 0", c, i, flush_o[i]);
        end
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
`ifdef FLUSH_CTRL_STATS_EN
    exp_br = 4'hF;
`else
    exp_br = 4'h0;
`endif
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (br_o[i] !== exp_br || mis_o[i] !== 4'h0 || obs_vec(i) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL saturation dut%0d: got br=%0d mis=%0d (%h) expected br=%0d mis=0 (%h)",
                 i, br_o[i], mis_o[i], obs_vec(i), exp_br, exp_vec(i));
      end
    end
    advance();
  endtask

  task automatic test_random();
    logic [W-1:0] sp;
    for (int c = 0; c < 400; c++) begin
      sp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), sp, $urandom, 1'($urandom_range(0, 3) == 0));
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      advance();
    end
  endtask

  // ---------------------------------------------------------------------------
  // sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    model_reset();
    test_reset();
    test_taken_mispredict();
    test_wrap();
    test_stall_in_flush();
    test_back_to_back();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
